// File: rtl/fpu_addsub_seq.sv
// Sequential IEEE-754-style add/sub: one pipeline step per FSM state, RNE rounding,
// subnormals, specials and exception flags, behind a 4-phase req/ack handshake.
module fpu_addsub_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_in,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ack_out,
    output logic         valid_out,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);
    localparam int SW = MAN_W + 4;   // hidden, mantissa, G, R, S
    localparam int EW = EXP_W + 1;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
    state_t state, state_nx;

    logic [W-1:0]     la, lb;
    logic             lop;
    logic             u_sa, u_sb, u_nan, u_snan, u_inf_a, u_inf_b;
    logic [EXP_W-1:0] u_ea, u_eb;
    logic [MAN_W:0]   u_ga, u_gb;
    logic             al_sign, al_sub;
    logic [EXP_W-1:0] al_exp;
    logic [SW-1:0]    al_big, al_sml;
    logic             ad_sign;
    logic [EW-1:0]    ad_exp;
    logic [SW:0]      ad_sum;
    logic             nm_sign;
    logic [EW-1:0]    nm_exp;
    logic [SW-1:0]    nm_sig;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req_in) state_nx = S_UNPACK;
            S_UNPACK: state_nx = req_in ? S_ALIGN : S_IDLE;
            S_ALIGN:  state_nx = req_in ? S_ADD   : S_IDLE;
            S_ADD:    state_nx = req_in ? S_NORM  : S_IDLE;
            S_NORM:   state_nx = req_in ? S_ROUND : S_IDLE;
            S_ROUND:  state_nx = req_in ? S_DONE  : S_IDLE;
            S_DONE:   if (!req_in) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ack_out   = (state == S_DONE);
        valid_out = (state == S_DONE);
    end

    // Unpack: subnormals get effective exponent 1 and hidden bit 0
    logic [EXP_W-1:0] fa_e, fb_e;
    logic [MAN_W-1:0] fa_m, fb_m;
    logic             nan_a, nan_b;
    always_comb begin
        fa_e  = la[W-2:MAN_W];
        fb_e  = lb[W-2:MAN_W];
        fa_m  = la[MAN_W-1:0];
        fb_m  = lb[MAN_W-1:0];
        nan_a = (fa_e == EXP_ONES) && (fa_m != '0);
        nan_b = (fb_e == EXP_ONES) && (fb_m != '0);
    end

    // Align: operands ordered by magnitude so the subtract never goes negative
    logic             a_big;
    logic [EXP_W-1:0] d;
    logic [SW-1:0]    ext, shr, mask, sml;
    logic [MAN_W:0]   sg;
    always_comb begin
        a_big = {u_ea, u_ga} >= {u_eb, u_gb};
        d     = a_big ? u_ea - u_eb : u_eb - u_ea;
        sg    = a_big ? u_gb : u_ga;
        ext   = {sg, 3'b000};
        shr   = ext >> d;
        mask  = ~({SW{1'b1}} << d);
        if (32'(d) >= MAN_W + 3) sml = {{(SW-1){1'b0}}, |sg};
        else                     sml = {shr[SW-1:1], shr[0] | (|(ext & mask))};
    end

    logic [SW:0] sum;
    always_comb sum = al_sub ? {1'b0, al_big} - {1'b0, al_sml} : {1'b0, al_big} + {1'b0, al_sml};

    // Normalise: left shift clamped so exponent never drops below 1
    int            lz, maxsh, shl;
    logic [SW-1:0] n_sig;
    logic [EW-1:0] n_exp;
    always_comb begin
        lz = SW;
        for (int i = 0; i < SW; i++) if (ad_sum[i]) lz = SW - 1 - i;
        maxsh = int'(ad_exp) - 1;
        shl   = (lz < maxsh) ? lz : maxsh;
        if (ad_sum[SW]) begin
            n_sig = {ad_sum[SW:2], ad_sum[1] | ad_sum[0]};
            n_exp = ad_exp + EW'(1);
        end else begin
            n_sig = ad_sum[SW-1:0] << shl;
            n_exp = ad_exp - EW'(shl);
        end
    end

    logic             inc, nx;
    logic [MAN_W+1:0] mant;
    logic [EW-1:0]    r_exp;
    logic [W-1:0]     r_res;
    logic [3:0]       r_flg;
    always_comb begin
        nx    = |nm_sig[2:0];
        inc   = nm_sig[2] & (nm_sig[1] | nm_sig[0] | nm_sig[3]);
        mant  = {1'b0, nm_sig[SW-1:3]} + (MAN_W+2)'(inc);
        r_exp = nm_exp;
        if (mant[MAN_W+1]) begin
            mant  = mant >> 1;
            r_exp = r_exp + EW'(1);
        end
        if (r_exp >= {1'b0, EXP_ONES}) begin
            r_res = {nm_sign, EXP_ONES, {MAN_W{1'b0}}};
            r_flg = 4'b0101;
        end else begin
            r_res = {nm_sign, mant[MAN_W] ? r_exp[EXP_W-1:0] : {EXP_W{1'b0}}, mant[MAN_W-1:0]};
            r_flg = {2'b00, ~mant[MAN_W] & nx, nx};
        end
        // Specials override the arithmetic path
        if (u_nan) begin
            r_res = QNAN;
            r_flg = {u_snan, 3'b000};
        end else if (u_inf_a && u_inf_b && (u_sa != u_sb)) begin
            r_res = QNAN;
            r_flg = 4'b1000;
        end else if (u_inf_a || u_inf_b) begin
            r_res = {u_inf_a ? u_sa : u_sb, EXP_ONES, {MAN_W{1'b0}}};
            r_flg = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            la <= '0; lb <= '0; lop <= 1'b0;
            u_sa <= 1'b0; u_sb <= 1'b0; u_nan <= 1'b0; u_snan <= 1'b0;
            u_inf_a <= 1'b0; u_inf_b <= 1'b0;
            u_ea <= '0; u_eb <= '0; u_ga <= '0; u_gb <= '0;
            al_sign <= 1'b0; al_sub <= 1'b0; al_exp <= '0; al_big <= '0; al_sml <= '0;
            ad_sign <= 1'b0; ad_exp <= '0; ad_sum <= '0;
            nm_sign <= 1'b0; nm_exp <= '0; nm_sig <= '0;
            result <= '0; flags <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_in) begin
                    la <= a; lb <= b; lop <= op_sub;
                end
                S_UNPACK: begin
                    u_sa    <= la[W-1];
                    u_sb    <= lb[W-1] ^ lop;
                    u_ea    <= (fa_e == '0) ? EXP_W'(1) : fa_e;
                    u_eb    <= (fb_e == '0) ? EXP_W'(1) : fb_e;
                    u_ga    <= {fa_e != '0, fa_m};
                    u_gb    <= {fb_e != '0, fb_m};
                    u_nan   <= nan_a | nan_b;
                    u_snan  <= (nan_a & ~fa_m[MAN_W-1]) | (nan_b & ~fb_m[MAN_W-1]);
                    u_inf_a <= (fa_e == EXP_ONES) && (fa_m == '0);
                    u_inf_b <= (fb_e == EXP_ONES) && (fb_m == '0);
                end
                S_ALIGN: begin
                    al_sign <= a_big ? u_sa : u_sb;
                    al_exp  <= a_big ? u_ea : u_eb;
                    al_big  <= {a_big ? u_ga : u_gb, 3'b000};
                    al_sml  <= sml;
                    al_sub  <= u_sa ^ u_sb;
                end
                S_ADD: begin
                    ad_sum  <= sum;
                    ad_exp  <= {1'b0, al_exp};
                    // exact cancellation gives +0 under RNE
                    ad_sign <= (al_sub && sum == '0) ? 1'b0 : al_sign;
                end
                S_NORM: begin
                    nm_sig  <= n_sig;
                    nm_exp  <= n_exp;
                    nm_sign <= ad_sign;
                end
                S_ROUND: if (req_in) begin
                    result <= r_res;
                    flags  <= r_flg;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Scoreboard bench for fpu_addsub_seq (FP16): expected results are queued at issue
// and popped when the handshake completes.
module tb_fpu_addsub_seq;
    logic        clk = 1'b0;
    logic        rst, req_in, op_sub;
    logic [15:0] a, b, result;
    logic        ack_out, valid_out;
    logic [3:0]  flags;

    fpu_addsub_seq dut (
        .clk(clk), .rst(rst), .req_in(req_in), .op_sub(op_sub), .a(a), .b(b),
        .ack_out(ack_out), .valid_out(valid_out), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a, b;
        logic        op;
        logic [15:0] r;
        logic [3:0]  f;
    } vec_t;

    logic [19:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // Drive one full handshake; returns observed result/flags and cycles to ack.
    task automatic do_op(input vec_t v, output logic [15:0] r, output logic [3:0] f, output int lat);
        exp_q.push_back({v.r, v.f});
        @(negedge clk);
        a = v.a; b = v.b; op_sub = v.op; req_in = 1'b1;
        lat = 0;
        while (!ack_out && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result; f = flags;
        @(negedge clk);
        req_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_in = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({ack_out, valid_out, result, flags} !== 22'd0) begin
            n_err++;
            $display("FAIL reset: ack=%b valid=%b result=%h flags=%b, want all 0", ack_out, valid_out, result, flags);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_basic;
        vec_t tbl[5] = '{
            '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000},
            '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000},
            '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000},
            '{16'h4000, 16'h3C00, 1'b0, 16'h4200, 4'b0000},
            '{16'h3C00, 16'h4000, 1'b1, 16'hBC00, 4'b0000}};
        logic [15:0] r; logic [3:0] f; int lat; logic [19:0] e;
        foreach (tbl[i]) begin
            do_op(tbl[i], r, f, lat);
            e = exp_q.pop_front();
            n_vec++;
            if ({r, f} !== e || lat != 6) begin
                n_err++;
                $display("FAIL basic[%0d]: got %h/%b lat %0d, want %h/%b lat 6", i, r, f, lat, e[19:4], e[3:0]);
            end
        end
    endtask

    task automatic test_rne;
        vec_t tbl[3] = '{
            '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001},
            '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001},
            '{16'h3C00, 16'h1400, 1'b0, 16'h3C01, 4'b0000}};
        logic [15:0] r; logic [3:0] f; int lat; logic [19:0] e;
        foreach (tbl[i]) begin
            do_op(tbl[i], r, f, lat);
            e = exp_q.pop_front();
            n_vec++;
            if ({r, f} !== e || lat != 6) begin
                n_err++;
                $display("FAIL rne[%0d]: got %h/%b lat %0d, want %h/%b lat 6", i, r, f, lat, e[19:4], e[3:0]);
            end
        end
    endtask

    task automatic test_specials;
        vec_t tbl[7] = '{
            '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101},
            '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b1000},
            '{16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 4'b1000},
            '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'b0000},
            '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000},
            '{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 4'b0000},
            '{16'hFC00, 16'h7C00, 1'b1, 16'hFC00, 4'b0000}};
        logic [15:0] r; logic [3:0] f; int lat; logic [19:0] e;
        foreach (tbl[i]) begin
            do_op(tbl[i], r, f, lat);
            e = exp_q.pop_front();
            n_vec++;
            if ({r, f} !== e || lat != 6) begin
                n_err++;
                $display("FAIL special[%0d]: got %h/%b lat %0d, want %h/%b lat 6", i, r, f, lat, e[19:4], e[3:0]);
            end
        end
    endtask

    task automatic test_subnormal;
        vec_t tbl[5] = '{
            '{16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000},
            '{16'h0400, 16'h0001, 1'b1, 16'h03FF, 4'b0000},
            '{16'h03FF, 16'h0001, 1'b0, 16'h0400, 4'b0000},
            '{16'h8000, 16'h0000, 1'b1, 16'h8000, 4'b0000},
            '{16'h0000, 16'h8000, 1'b0, 16'h0000, 4'b0000}};
        logic [15:0] r; logic [3:0] f; int lat; logic [19:0] e;
        foreach (tbl[i]) begin
            do_op(tbl[i], r, f, lat);
            e = exp_q.pop_front();
            n_vec++;
            if ({r, f} !== e || lat != 6) begin
                n_err++;
                $display("FAIL subnorm[%0d]: got %h/%b lat %0d, want %h/%b lat 6", i, r, f, lat, e[19:4], e[3:0]);
            end
        end
    endtask

    task automatic test_abort;
        logic [15:0] r; logic [3:0] f; int lat; logic [19:0] e; int acks;
        do_op('{16'h4000, 16'h3C00, 1'b0, 16'h4200, 4'b0000}, r, f, lat);
        e = exp_q.pop_front();
        n_vec++;
        if ({r, f} !== e || lat != 6) begin
            n_err++;
            $display("FAIL abort_pre: got %h/%b lat %0d, want %h/%b lat 6", r, f, lat, e[19:4], e[3:0]);
        end
        @(negedge clk);
        a = 16'h3C00; b = 16'h3C00; op_sub = 1'b0; req_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) req_in = 1'b0;
        acks = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ack_out || valid_out) acks++;
        end
        n_vec++;
        if (acks != 0 || result !== 16'h4200 || flags !== 4'b0000) begin
            n_err++;
            $display("FAIL abort: ack cycles %0d result %h flags %b, want 0 cycles 4200/0000", acks, result, flags);
        end
        do_op('{16'h3C00, 16'h1400, 1'b0, 16'h3C01, 4'b0000}, r, f, lat);
        e = exp_q.pop_front();
        n_vec++;
        if ({r, f} !== e || lat != 6) begin
            n_err++;
            $display("FAIL abort_post: got %h/%b lat %0d, want %h/%b lat 6", r, f, lat, e[19:4], e[3:0]);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] r; logic [3:0] f; int lat; logic [19:0] e;
        do_op('{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101}, r, f, lat);
        void'(exp_q.pop_front());
        @(negedge clk);
        a = 16'h3C00; b = 16'h3C00; op_sub = 1'b0; req_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({ack_out, valid_out, result, flags} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_mid: ack=%b valid=%b result=%h flags=%b, want all 0", ack_out, valid_out, result, flags);
        end
        @(negedge clk);
        rst = 1'b0; req_in = 1'b0;
        do_op('{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000}, r, f, lat);
        e = exp_q.pop_front();
        n_vec++;
        if ({r, f} !== e || lat != 6) begin
            n_err++;
            $display("FAIL reset_recover: got %h/%b lat %0d, want %h/%b lat 6", r, f, lat, e[19:4], e[3:0]);
        end
    endtask

    task automatic test_hold;
        int lat; int bad; logic [19:0] e;
        exp_q.push_back({16'h3C02, 4'b0001});
        @(negedge clk);
        a = 16'h3C01; b = 16'h1000; op_sub = 1'b0; req_in = 1'b1;
        lat = 0;
        while (!ack_out && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = exp_q.pop_front();
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!ack_out || !valid_out || {result, flags} !== e) bad++;
        end
        n_vec++;
        if (bad != 0 || lat != 6) begin
            n_err++;
            $display("FAIL hold: %0d bad held cycles lat %0d result %h/%b, want 0 bad lat 6 %h/%b",
                     bad, lat, result, flags, e[19:4], e[3:0]);
        end
        @(negedge clk) req_in = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (ack_out !== 1'b0 || valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL release: ack=%b valid=%b, want 0/0", ack_out, valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rne();
        test_specials();
        test_subnormal();
        test_abort();
        test_reset_mid();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
